// File: rtl/l1i_line_fill.sv
// Direct-mapped L1 instruction cache with an 8-beat line-fill engine, one fetch in flight.
// Build with L1I_STATS_EN defined to get saturating hit/miss counters; otherwise they read 0.

module l1i_set_meta #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o
);
  logic             vld_q;
  logic [TAG_W-1:0] tag_q;

  // Clear beats set so a coincident invalidate never leaves a line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      tag_q <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else if (set_i) begin
      vld_q <= 1'b1;
      tag_q <= tag_i;
    end
  end

  assign vld_o = vld_q;
  assign tag_o = tag_q;
endmodule

module l1i_line_fill #(
  parameter int DATA_W   = 64,
  parameter int NUM_SETS = 16,
  parameter int ADDR_W   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_l1i,
  input  logic [ADDR_W-1:0]      l1i_addr,
  output logic [0:7][DATA_W-1:0] l1i_data,
  output logic                   l1i_ready,
  input  logic                   inv_all,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int LINE_W = ADDR_W - 6;
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL, S_RESP, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [LINE_W-1:0]        addr_q, addr_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [2:0]               beat_q, beat_d;
  logic                     inv_seen_q, inv_seen_d;
  logic                     ready_q, ready_d;
  logic [0:7][DATA_W-1:0]   data_q, data_d;

  logic [0:7][DATA_W-1:0]   line_mem_q [NUM_SETS];
  logic [NUM_SETS-1:0]              set_vld;
  logic [NUM_SETS-1:0][TAG_W-1:0]   set_tag;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             lookup_hit, lookup_miss, fill_we, fill_done;
  logic             unused_offset;

  assign unused_offset = ^l1i_addr[5:0];
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[LINE_W-1:IDX_W];
  // An invalidate landing on the lookup edge must force a miss.
  assign hit = set_vld[idx] && (set_tag[idx] == tag) && !inv_all;

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    l1i_set_meta #(.TAG_W(TAG_W)) u_meta (
      .clk   (clk),
      .rst   (rst),
      .clr_i (inv_all || (lookup_miss && idx == IDX_W'(s))),
      .set_i (fill_done && !inv_seen_q && idx == IDX_W'(s)),
      .tag_i (tag),
      .vld_o (set_vld[s]),
      .tag_o (set_tag[s])
    );
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    beat_d      = beat_q;
    inv_seen_d  = inv_seen_q;
    ready_d     = 1'b0;
    data_d      = data_q;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_l1i) begin
          addr_d  = l1i_addr[ADDR_W-1:6];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        inv_seen_d = 1'b0;
        if (hit) begin
          lookup_hit = 1'b1;
          state_d    = S_RESP;
        end else begin
          lookup_miss = 1'b1;
          mem_addr_d  = {addr_q, 6'b0};
          state_d     = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (inv_all) inv_seen_d = 1'b1;
        if (mem_ack) begin
          beat_d  = 3'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (inv_all) inv_seen_d = 1'b1;
        if (mem_rvalid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            fill_done = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        ready_d = 1'b1;
        data_d  = line_mem_q[idx];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!read_l1i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      beat_q     <= 3'd0;
      inv_seen_q <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      beat_q     <= beat_d;
      inv_seen_q <= inv_seen_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
    end
  end

  // Line storage carries no reset; a set is only read once its valid bit says so.
  always_ff @(posedge clk) begin
    if (fill_we) line_mem_q[idx][beat_q] <= mem_rdata;
  end

  assign mem_req   = (state_q == S_MISS_REQ);
  assign mem_addr  = mem_addr_q;
  assign l1i_ready = ready_q;
  assign l1i_data  = data_q;

`ifdef L1I_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (lookup_hit && hit_q != '1)   hit_q  <= hit_q + 32'd1;
      if (lookup_miss && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_stats;
  assign unused_stats = lookup_hit;
  assign hit_count    = '0;
  assign miss_count   = '0;
`endif
endmodule

// File: tb/tb_l1i_line_fill.sv
// Scoreboard bench for l1i_line_fill: randomized fetches, a memory responder and a line-level cache model.
module tb_l1i_line_fill;
  typedef logic [0:7][63:0] line_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_stim = 1'b1, rst_mem = 1'b0, rst;
  logic inv_stim = 1'b0, inv_mem = 1'b0, inv_all;
  assign rst     = rst_stim | rst_mem;
  assign inv_all = inv_stim | inv_mem;

  logic        read_l1i;
  logic [63:0] l1i_addr;
  line_t       l1i_data;
  logic        l1i_ready;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack, mem_rvalid;
  logic [63:0] mem_rdata;
  logic [31:0] hit_count, miss_count;

  l1i_line_fill #(.DATA_W(64), .NUM_SETS(16), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .read_l1i(read_l1i), .l1i_addr(l1i_addr),
    .l1i_data(l1i_data), .l1i_ready(l1i_ready), .inv_all(inv_all),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, beat7_cyc = 0, serial = 0;
  int inv_at_beat = -1, rst_at_beat = -1;
  bit rst_fired = 0;

  // Reference model: per-set valid/tag/line, plus expected responses and bursts.
  bit          mv [16];
  logic [53:0] mt [16];
  line_t       ml [16];
  int          hits = 0, misses = 0, nfills = 0;
  logic [63:0] burst_q [$];
  line_t       exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic line_t gen_line(input logic [63:0] base, input int s);
    line_t l;
    logic [31:0] sv;
    sv = s;
    for (int i = 0; i < 8; i++) l[i] = {sv[15:0], base[31:0], 8'h00, 8'hA0 + 8'(i)};
    return l;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endtask

  task automatic chk_stats();
`ifdef L1I_STATS_EN
    chk("hit_count", hit_count, hits);
    chk("miss_count", miss_count, misses);
`else
    chk("hit_count", hit_count, 0);
    chk("miss_count", miss_count, 0);
`endif
  endtask

  // Monitor: pops the scoreboard on every ready pulse, checks data holds otherwise.
  line_t last_data, mon_e;
  bit    prev_rdy;
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
      prev_rdy  = 0;
    end else begin
      if (l1i_ready) begin
        chk("ready_pulse_width", prev_rdy, 0);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ready: got a ready pulse, expected none outstanding");
        end else begin
          mon_e = exp_q.pop_front();
          if (l1i_data !== mon_e) begin
            n_fail++;
            $display("FAIL line_data: got w0=%0h w7=%0h, expected w0=%0h w7=%0h",
                     l1i_data[0], l1i_data[7], mon_e[0], mon_e[7]);
          end
        end
        last_data = l1i_data;
      end else if (l1i_data !== last_data) begin
        n_chk++;
        n_fail++;
        $display("FAIL data_hold: got w0=%0h, expected held w0=%0h", l1i_data[0], last_data[0]);
      end
      prev_rdy = l1i_ready;
    end
  end

  // Memory responder: random ack delay, gapped beats, stray beats while idle.
  logic [63:0] ba;
  line_t       mline;
  initial begin
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      mem_ack    = 0;
      if (!rst && mem_req) begin
        ba = mem_addr;
        if (burst_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_burst: got burst at %0h, expected none", ba);
        end else chk("burst_addr", ba, burst_q.pop_front());
        mline = gen_line(ba, serial);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("req_held", {mem_req, mem_addr == ba}, 2'b11);
        end
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("req_drop_after_ack", mem_req, 0);
        for (int b = 0; b < 8; b++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mem_rvalid = 1;
          mem_rdata  = mline[b];
          inv_mem    = (b == inv_at_beat);
          @(posedge clk);
          #1;
          if (b == 7) beat7_cyc = cyc;
          if (b == rst_at_beat) begin
            rst_mem = 1;
            #1;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_ready", l1i_ready, 0);
            chk("rst_data_w0", l1i_data[0], 0);
            chk("rst_data_w7", l1i_data[7], 0);
            chk("rst_mem_addr", mem_addr, 0);
            rst_fired = 1;
          end
          @(negedge clk);
          mem_rvalid = 0;
          inv_mem    = 0;
        end
        serial++;
        if (rst_mem) begin
          repeat (3) @(negedge clk);
          rst_mem = 0;
        end
      end else if (!rst && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1;
        mem_rdata  = {$urandom, $urandom};
      end
    end
  end

  task automatic do_req(input logic [63:0] a, input int hold, input bit inv_with);
    int idx, n, req_cyc;
    logic [53:0] tg;
    logic [63:0] base;
    bit hit;
    line_t e;
    idx  = int'(a[9:6]);
    tg   = a[63:10];
    base = {a[63:6], 6'b0};
    if (inv_with) clr_model();
    hit = mv[idx] && mt[idx] == tg;
    if (hit) begin
      e = ml[idx];
      hits++;
    end else begin
      misses++;
      e = gen_line(base, nfills);
      nfills++;
      burst_q.push_back(base);
      if (inv_at_beat >= 0) clr_model();
      else begin
        mv[idx] = 1; mt[idx] = tg; ml[idx] = e;
      end
    end
    exp_q.push_back(e);
    read_l1i = 1;
    l1i_addr = a;
    inv_stim = inv_with;
    @(posedge clk);
    #1;
    req_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      inv_stim = 0;
      l1i_addr = {$urandom, $urandom};
      n++;
    end while (!l1i_ready && n < 400);
    if (!l1i_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got no ready for %0h, expected one", a);
    end else if (hit) chk("hit_latency", cyc - req_cyc, 2);
    else chk("miss_latency", cyc - beat7_cyc, 1);
    repeat (hold) @(negedge clk);
    read_l1i = 0;
    @(negedge clk);
  endtask

  task automatic do_rst_req(input logic [63:0] a);
    int n;
    inv_stim = 1;
    @(negedge clk);
    inv_stim = 0;
    clr_model();
    burst_q.push_back({a[63:6], 6'b0});
    nfills++;
    rst_at_beat = 3;
    read_l1i = 1;
    l1i_addr = a;
    n = 0;
    while (!rst_fired && n < 400) begin @(negedge clk); n++; end
    if (!rst_fired) begin
      n_chk++; n_fail++;
      $display("FAIL rst_timeout: got no beat 3, expected mid-fill reset");
    end
    read_l1i = 0;
    n = 0;
    while (rst_mem && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    clr_model();
    hits = 0; misses = 0;
    rst_at_beat = -1;
    rst_fired = 0;
    chk("post_rst_data", l1i_data[0], 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    chk_stats();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    read_l1i = 0;
    l1i_addr = '0;
    clr_model();
    repeat (3) @(negedge clk);
    chk("reset_ready", l1i_ready, 0);
    chk("reset_data_w0", l1i_data[0], 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk_stats();
    rst_stim = 0;
    @(negedge clk);

    do_req(64'h1008, 0, 0);
    do_req(64'h1030, 0, 0);
    chk_stats();
    do_req(64'h1000, 1, 0);
    do_req(64'h1400, 0, 0);
    do_req(64'h1000, 0, 0);
    do_req(64'h1800, 3, 0);
    do_req(64'h1800, 3, 0);
    inv_at_beat = 4;
    do_req(64'h2000, 0, 0);
    inv_at_beat = -1;
    do_req(64'h2000, 0, 0);
    do_req(64'h1400, 0, 0);
    do_req(64'h1400, 0, 1);
    do_req(64'h1400, 2, 0);
    chk_stats();
    do_rst_req(64'h3010);
    do_req(64'h3010, 0, 0);
    do_req(64'h3010, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      a = 64'h1000 + (64'($urandom_range(0, 3)) << 10) + (64'($urandom_range(0, 3)) << 6)
          + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) inv_at_beat = $urandom_range(0, 7);
      do_req(a, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      inv_at_beat = -1;
      if ($urandom_range(0, 7) == 0) begin
        inv_stim = 1;
        @(negedge clk);
        inv_stim = 0;
        clr_model();
      end
    end

    repeat (5) @(negedge clk);
    chk_stats();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("burst_q_empty", burst_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l1i_line_fill.md
Name: l1i_line_fill

Overview:
- Instruction-side L1 cache and line-fill engine that sits directly upstream of each Ember thread's fetch stage.
- Serves the thread's read_l1i/l1i_addr request with an aligned 8-word line on l1i_data plus an l1i_ready pulse.
- Lookup is direct-mapped; on a miss the line is fetched as an 8-beat burst from the memory side.

Parameters:
DATA_W, 64, word width in bits; one line = 8 words = LINE_BYTES (64) bytes
NUM_SETS, 16, direct-mapped sets; power of two, at least 2
ADDR_W, 64, address width presented by the thread

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
read_l1i  in  1  fetch request level, held high until l1i_ready is seen
l1i_addr  in  ADDR_W  byte address; only the line base is used
l1i_data  out  DATA_W x [0:7]  returned line, word i = bytes base+8i..base+8i+7
l1i_ready  out  1  one-cycle pulse: l1i_data is valid for the accepted request
inv_all  in  1  invalidate all sets (single-cycle pulse)
mem_req  out  1  burst read request, held until mem_ack
mem_addr  out  ADDR_W  line base address of the burst
mem_ack  in  1  memory accepted the burst
mem_rvalid  in  1  one beat of read data valid
mem_rdata  in  DATA_W  beat data, word order 0..7
hit_count  out  32  hits (see Optional Feature)
miss_count  out  32  misses (see Optional Feature)

Behaviour:
- Address split: offset = addr[5:0] (ignored); index = addr[6 +: log2(NUM_SETS)]; tag = remaining upper bits. Line base = addr with bits [5:0] cleared.
- Storage: per set, a valid bit, a tag, and 8 DATA_W words. Contents are registered and the power-on contents of data are don't-care.
- Reset (asynchronous): state IDLE, all valid bits 0, l1i_ready 0, l1i_data all 0, mem_req 0, mem_addr 0, beat counter 0, counters 0.
- Reset asserted mid-fill: mem_req drops immediately, the partial line is discarded, and remaining beats after reset are ignored.
- FSM states: IDLE, LOOKUP, MISS_REQ, FILL, RESP, DONE.
  - IDLE: when read_l1i=1, latch l1i_addr; go to LOOKUP.
  - LOOKUP: compare the tag of the latched index. Hit goes to RESP. Miss drives mem_req=1 and mem_addr=line base, and goes to MISS_REQ.
  - MISS_REQ: hold mem_req and mem_addr until mem_ack=1; then drop mem_req and clear the beat counter; go to FILL.
  - FILL: each mem_rvalid writes mem_rdata into word[beat] of the set; beat increments 0..7. After beat 7, set tag and valid; go to RESP. Cycles without mem_rvalid simply wait, with no timeout.
  - RESP: drive l1i_data from the set; pulse l1i_ready=1 for exactly this cycle; go to DONE.
  - DONE: l1i_data holds its value; remain until read_l1i=0, then go to IDLE. This prevents a still-high read_l1i from re-triggering.
- Latency:
  - Hit: request sampled at edge 0; l1i_ready high during the cycle after edge 2.
  - Miss: ready one cycle after the edge that captures beat 7.
- l1i_data changes only on entry to RESP and is stable otherwise.
- mem_rvalid outside FILL is ignored.
- A change of l1i_addr after acceptance is ignored until the next IDLE.
- inv_all:
  - Clears every valid bit at the next edge.
  - In LOOKUP on the same edge, it forces a miss.
  - During MISS_REQ or FILL, the fill completes and the line is returned, but valid is left 0.
  - inv_all in IDLE coincident with read_l1i: the request is accepted and misses.
- The same line requested twice back-to-back: the second request hits.

Optional Feature:
- Macro: L1I_STATS_EN.
- Defined:
  - hit_count increments on each LOOKUP hit; miss_count increments on each LOOKUP miss.
  - Both saturate at 0xFFFFFFFF and clear on rst.
  - inv_all does not clear them.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Cold miss: reset, then read_l1i with addr 0x1008. Expect mem_req with mem_addr=0x1000. Ack, then 8 beats 0xA0..0xA7. Expect l1i_ready as a 1-cycle pulse, with l1i_data[0]=0xA0 and l1i_data[7]=0xA7.
- Hit after fill: request addr 0x1030. Expect no mem_req, l1i_ready exactly 2 cycles after the request edge, and data identical; with the macro, hit_count=1 and miss_count=1.
- Conflict: with NUM_SETS=16, request 0x1000 then 0x1400 (same index, different tag). Expect a second burst at 0x1400. A following request to 0x1000 misses again.
- Held request / stalls: keep read_l1i high 3 cycles past ready, and space beats with idle gaps. Expect exactly one l1i_ready and one burst per request, and correct word order.
- inv_all during FILL at beat 4: line 0x2000 is returned correctly. A re-request of 0x2000 then misses and issues a new burst.
- Async reset at beat 3: mem_req=0 and l1i_ready=0 immediately. After release, a request to the same address misses and refetches.
